// File: rtl/dbns_decoder.sv
// Sequential DBNS-to-binary decoder: walks the captured digit map one position per
// cycle, summing 2^i*3^j terms into a saturating accumulator.
module dbns_decoder #(
  parameter int NUM_I    = 4,
  parameter int NUM_J    = 3,
  parameter int OUT_BITS = 10,
  parameter int CNT_BITS = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [NUM_I*NUM_J-1:0]   digit_map,
  output logic                     busy,
  output logic                     done,
  output logic [OUT_BITS-1:0]      result,
  output logic                     overflow,
  output logic [CNT_BITS-1:0]      term_count,
  output logic [1:0]               state_dbg
);

  // Handshake: start is a level request sampled only while idle; done is a
  // single-cycle pulse during which result/overflow/term_count are valid.

  function automatic int max_term();
    int v;
    v = 1 << (NUM_I - 1);
    for (int j = 0; j < NUM_J - 1; j++) v = v * 3;
    return v;
  endfunction

  localparam int N      = NUM_I * NUM_J;
  localparam int TERM_W = $clog2(max_term() + 1);
  localparam int K_W    = (N > 1) ? $clog2(N) : 1;
  localparam int I_W    = (NUM_I > 1) ? $clog2(NUM_I) : 1;
  localparam int ACC_W  = OUT_BITS + 1;
  localparam int SUM_W  = ((ACC_W > TERM_W) ? ACC_W : TERM_W) + 1;
  localparam logic [SUM_W-1:0] SAT = {{(SUM_W-OUT_BITS){1'b0}}, {OUT_BITS{1'b1}}};
  localparam logic [K_W-1:0]   K_LAST = K_W'(N - 1);
  localparam logic [I_W-1:0]   I_LAST = I_W'(NUM_I - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0]        map_q;
  logic [K_W-1:0]      k_q;
  logic [I_W-1:0]      i_q;
  logic [TERM_W-1:0]   pow3_q;
  logic [ACC_W-1:0]    acc_q;
  logic                ovf_q;
  logic [CNT_BITS-1:0] cnt_q;

  logic [TERM_W-1:0]   term;
  logic [SUM_W-1:0]    sum;
  logic                bit_set;
  logic [ACC_W-1:0]    acc_nxt;
  logic                ovf_nxt;
  logic [CNT_BITS-1:0] cnt_nxt;

  assign term    = pow3_q << i_q;
  assign sum     = SUM_W'(acc_q) + SUM_W'(term);
  assign bit_set = map_q[k_q];

  // Once saturated the sum can only grow, so the sticky flag keeps it pinned.
  always_comb begin
    acc_nxt = acc_q;
    ovf_nxt = ovf_q;
    cnt_nxt = cnt_q;
    if (bit_set) begin
      cnt_nxt = cnt_q + 1'b1;
      if (ovf_q || (sum > SAT)) begin
        acc_nxt = ACC_W'(SAT);
        ovf_nxt = 1'b1;
      end else begin
        acc_nxt = ACC_W'(sum);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SCAN;
      S_SCAN:  if (k_q == K_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      map_q      <= '0;
      k_q        <= '0;
      i_q        <= '0;
      pow3_q     <= TERM_W'(1);
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      result     <= '0;
      overflow   <= 1'b0;
      term_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            map_q  <= digit_map;
            k_q    <= '0;
            i_q    <= '0;
            pow3_q <= TERM_W'(1);
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
          end
        end
        S_SCAN: begin
          acc_q <= acc_nxt;
          ovf_q <= ovf_nxt;
          cnt_q <= cnt_nxt;
          k_q   <= k_q + 1'b1;
          // Moving to the next ternary row multiplies by three: p + 2p.
          if (i_q == I_LAST) begin
            i_q    <= '0;
            pow3_q <= pow3_q + (pow3_q << 1);
          end else begin
            i_q <= i_q + 1'b1;
          end
          if (k_q == K_LAST) begin
            result     <= acc_nxt[OUT_BITS-1:0];
            overflow   <= ovf_nxt;
            term_count <= cnt_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == S_SCAN);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

endmodule
